// File: rtl/top_nco_cnt_disp_pkg.sv
// Shared constants for the seconds-counter display: segment codes, digit count
// and the BCD-to-7-segment decoder (segments ordered {a,b,c,d,e,f,g}).
package top_nco_cnt_disp_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0     = 7'h7E;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6D;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5B;
   localparam logic [6:0] SEG_6     = 7'h5F;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h7B;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Any digit code above 9 decodes to blank, so this doubles as the blank code.
   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   typedef logic [2:0] scan_idx_t;

   function automatic logic [6:0] dec2seg(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/top_nco_cnt_disp_nco.sv
// Divide-by-DIV tick generator: a registered one-cycle pulse every DIV clocks,
// first pulse on the DIV-th rising edge after reset release.
module nco #(
   parameter int unsigned DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         o_tick <= 1'b0;
      end else if (acc == LAST) begin
         acc    <= '0;
         o_tick <= 1'b1;
      end else begin
         acc    <= acc + W'(1);
         o_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/top_nco_cnt_disp.sv
// Seconds counter 0..CNT_MAX on a 6-digit multiplexed 7-segment display.
// Define DP_BLINK_EN to blink the tens-digit decimal point on odd counts.
module top_nco_cnt_disp
   import top_nco_cnt_disp_pkg::*;
#(
   parameter int unsigned CNT_DIV  = 50_000_000,
   parameter int unsigned SCAN_DIV = 50_000,
   parameter int unsigned CNT_MAX  = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [5:0] o_seg_enb,
   output logic       o_seg_dp,
   output logic [6:0] o_seg
);

   logic       cnt_tick;
   logic       scan_tick;
   logic [6:0] count;
   scan_idx_t  scan_idx;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [3:0] digit;
   logic [6:0] seg_next;
   logic [5:0] enb_next;
   logic       dp_next;

   nco #(.DIV(CNT_DIV)) u_cnt_nco (
      .clk    (clk),
      .rst_n  (rst_n),
      .o_tick (cnt_tick)
   );

   nco #(.DIV(SCAN_DIV)) u_scan_nco (
      .clk    (clk),
      .rst_n  (rst_n),
      .o_tick (scan_tick)
   );

   // Count and scan index advance independently; coincident ticks both apply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         scan_idx <= '0;
      end else begin
         if (cnt_tick)
            count <= (count == 7'(CNT_MAX)) ? 7'd0 : count + 7'd1;
         if (scan_tick)
            scan_idx <= (scan_idx == scan_idx_t'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
      end
   end

   always_comb begin
      tens = 4'(count / 7'd10);
      ones = 4'(count % 7'd10);

      digit = DIGIT_BLANK;
      if (scan_idx == 3'd0)
         digit = ones;
      else if (scan_idx == 3'd1)
         digit = tens;

      seg_next = dec2seg(digit);
      enb_next = ~(6'b000001 << scan_idx);
`ifdef DP_BLINK_EN
      dp_next  = (scan_idx == 3'd1) && count[0];
`else
      dp_next  = 1'b0;
`endif
   end

   // Enables and segments are registered together so digits never ghost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_seg_enb <= 6'b111110;
         o_seg     <= SEG_0;
         o_seg_dp  <= 1'b0;
      end else begin
         o_seg_enb <= enb_next;
         o_seg     <= seg_next;
         o_seg_dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_top_nco_cnt_disp.sv
// Scoreboard bench for top_nco_cnt_disp with CNT_DIV=40, SCAN_DIV=4.
// Expected display states are queued against a cycle number after reset release.
module tb_top_nco_cnt_disp;

`ifdef DP_BLINK_EN
   localparam logic BLINK = 1'b1;
`else
   localparam logic BLINK = 1'b0;
`endif

   typedef struct {
      int         at;
      logic [5:0] enb;
      logic [6:0] seg;
      logic       dp;
      string      name;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [5:0] o_seg_enb;
   logic       o_seg_dp;
   logic [6:0] o_seg;

   int   cyc;
   int   n_cmp;
   int   n_fail;
   exp_t exp_q[$];

   top_nco_cnt_disp #(
      .CNT_DIV  (40),
      .SCAN_DIV (4),
      .CNT_MAX  (59)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .o_seg_enb (o_seg_enb),
      .o_seg_dp  (o_seg_dp),
      .o_seg     (o_seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since the last reset release; 0 while reset is held.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cyc <= 0;
      else
         cyc <= cyc + 1;
   end

   task automatic checkOutput(input exp_t e);
      n_cmp++;
      if (o_seg_enb !== e.enb || o_seg !== e.seg || o_seg_dp !== e.dp) begin
         n_fail++;
         $display("[TB] FAIL %s cyc=%0d: got enb=%b seg=%h dp=%b, expected enb=%b seg=%h dp=%b",
                  e.name, cyc, o_seg_enb, o_seg, o_seg_dp, e.enb, e.seg, e.dp);
      end
   endtask

   // Monitor: entries with at<0 are checked at the very next falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         if (exp_q[0].at < 0 || exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end else if (exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s missed: cyc=%0d, required cyc=%0d", e.name, cyc, e.at);
         end
      end
   end

   task automatic pushExp(input int at, input logic [5:0] enb, input logic [6:0] seg,
                          input logic dp, input string name);
      exp_t e;
      e.at = at; e.enb = enb; e.seg = seg; e.dp = dp; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Drive reset; when asserting, queue the reset display for the next few cycles.
   task automatic applyStimulus(input logic rst_val, input int hold);
      rst_n = rst_val;
      if (!rst_val) begin
         for (int i = 0; i < hold; i++)
            pushExp(-1, 6'b111110, 7'h7E, 1'b0, "reset_state");
         waitDrain(hold + 4);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;

      applyStimulus(1'b0, 10);
      @(negedge clk); #1;
      applyStimulus(1'b1, 0);

      // Output at cycle k shows idx=((k-2)/4)%6 and count=((k-2)/40)%60.
      pushExp(1,    6'b111110, 7'h7E, 1'b0,  "first_edge");
      pushExp(2,    6'b111110, 7'h7E, 1'b0,  "idx0_start");
      pushExp(5,    6'b111110, 7'h7E, 1'b0,  "idx0_end");
      pushExp(6,    6'b111101, 7'h7E, 1'b0,  "idx1_tens0");
      pushExp(10,   6'b111011, 7'h00, 1'b0,  "idx2_blank");
      pushExp(14,   6'b110111, 7'h00, 1'b0,  "idx3_blank");
      pushExp(18,   6'b101111, 7'h00, 1'b0,  "idx4_blank");
      pushExp(22,   6'b011111, 7'h00, 1'b0,  "idx5_blank");
      pushExp(26,   6'b111110, 7'h7E, 1'b0,  "scan_wrap");
      pushExp(50,   6'b111110, 7'h30, 1'b0,  "count1_ones");
      pushExp(122,  6'b111110, 7'h79, 1'b0,  "count3_ones");
      pushExp(126,  6'b111101, 7'h7E, BLINK, "count3_tens_dp");
      pushExp(174,  6'b111101, 7'h7E, 1'b0,  "count4_tens_dp");
      pushExp(410,  6'b111110, 7'h7E, 1'b0,  "count10_ones");
      pushExp(414,  6'b111101, 7'h30, 1'b0,  "count10_tens");
      pushExp(1490, 6'b111110, 7'h70, 1'b0,  "count37_ones");
      waitDrain(1600);

      @(posedge clk); #1;
      rst_n = 1'b0;
      pushExp(-1, 6'b111110, 7'h7E, 1'b0, "mid_reset_immediate");
      waitDrain(4);
      applyStimulus(1'b0, 3);
      @(negedge clk); #1;
      applyStimulus(1'b1, 0);

      pushExp(6,    6'b111101, 7'h7E, 1'b0,  "restart_idx1");
      pushExp(26,   6'b111110, 7'h7E, 1'b0,  "restart_count0");
      pushExp(50,   6'b111110, 7'h30, 1'b0,  "restart_count1");
      pushExp(2378, 6'b111110, 7'h7B, 1'b0,  "count59_ones");
      pushExp(2382, 6'b111101, 7'h5B, BLINK, "count59_tens_dp");
      pushExp(2401, 6'b011111, 7'h00, 1'b0,  "pre_wrap_idx5");
      pushExp(2402, 6'b111110, 7'h7E, 1'b0,  "wrap_ones");
      pushExp(2406, 6'b111101, 7'h7E, 1'b0,  "wrap_tens");
      waitDrain(2600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
